// File: rtl/cycle_pc_unit_if.sv
// Decoder-to-datapath bundle for the cycle/PC unit: control strobes and
// memory data in, instruction state and address out.
interface cycle_pc_unit_if;
   logic       I_cycle;
   logic       R_cycle;
   logic       PCL_ADL;
   logic       PCH_ADH;
   logic       ADD_ADL;
   logic       DL_ADH;
   logic       ADL_ABL;
   logic       ADH_ABH;
   logic       I_PC;
   logic       PCL_PCL;
   logic       PCH_PCH;
   logic       ADL_PCL;
   logic       ADH_PCH;
   logic [7:0] data_in;
   logic [7:0] add_in;
   logic [2:0] cycle;
   logic [7:0] IR;
   logic [7:0] DL;
   logic [15:0] pc;
   logic [15:0] addr;
   logic       sync;

   modport slave (
      input  I_cycle, R_cycle,
      input  PCL_ADL, PCH_ADH, ADD_ADL, DL_ADH,
      input  ADL_ABL, ADH_ABH,
      input  I_PC, PCL_PCL, PCH_PCH, ADL_PCL, ADH_PCH,
      input  data_in, add_in,
      output cycle, IR, DL, pc, addr, sync
   );

   modport master (
      output I_cycle, R_cycle,
      output PCL_ADL, PCH_ADH, ADD_ADL, DL_ADH,
      output ADL_ABL, ADH_ABH,
      output I_PC, PCL_PCL, PCH_PCH, ADL_PCL, ADH_PCH,
      output data_in, add_in,
      input  cycle, IR, DL, pc, addr, sync
   );
endinterface

// File: rtl/cycle_pc_unit.sv
// 6502-style instruction cycle counter, IR/DL latches, wired-AND ADL/ADH
// internal buses, address bus registers and 16-bit program counter.
module cycle_pc_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic            clk_ph2,
   input  logic            rst,
   cycle_pc_unit_if.slave  bus
);

   localparam logic [2:0] CYC_FETCH = 3'd0;
   localparam logic [2:0] CYC_RESET = 3'd7;
   localparam logic [7:0] IR_RESET  = 8'hEA;

   logic [2:0]  cycle_q, cycle_d;
   logic [7:0]  ir_q,    ir_d;
   logic [7:0]  dl_q;
   logic [7:0]  pcl_q,   pch_q;
   logic [7:0]  abl_q,   abl_d;
   logic [7:0]  abh_q,   abh_d;
   logic [15:0] pc_d;

   logic [7:0]  adl_bus;
   logic [7:0]  adh_bus;
   logic [7:0]  pcl_src;
   logic [7:0]  pch_src;

   // Precharged buses: every enabled driver can only pull bits low.
   always_comb begin
      adl_bus = 8'hFF;
      if (bus.PCL_ADL) adl_bus = adl_bus & pcl_q;
      if (bus.ADD_ADL) adl_bus = adl_bus & bus.add_in;
   end

   always_comb begin
      adh_bus = 8'hFF;
      if (bus.PCH_ADH) adh_bus = adh_bus & pch_q;
      if (bus.DL_ADH)  adh_bus = adh_bus & dl_q;
   end

   always_comb begin
      cycle_d = cycle_q;
      if (bus.R_cycle)      cycle_d = CYC_FETCH;
      else if (bus.I_cycle) cycle_d = cycle_q + 3'd1;
   end

   // Opcode is captured only on the fetch edge so the decoder keeps the old IR during cycle 0.
   always_comb begin
      ir_d = ir_q;
      if (cycle_q == CYC_FETCH) ir_d = bus.data_in;
   end

   always_comb begin
      abl_d = abl_q;
      abh_d = abh_q;
      if (bus.ADL_ABL) abl_d = adl_bus;
      if (bus.ADH_ABH) abh_d = adh_bus;
   end

   // Bus load wins over the PC self-path; without either the PC recirculates.
   always_comb begin
      pcl_src = pcl_q;
      pch_src = pch_q;
      if (bus.ADL_PCL)      pcl_src = adl_bus;
      else if (bus.PCL_PCL) pcl_src = pcl_q;
      if (bus.ADH_PCH)      pch_src = adh_bus;
      else if (bus.PCH_PCH) pch_src = pch_q;
      pc_d = {pch_src, pcl_src} + {15'd0, bus.I_PC};
   end

   always_ff @(posedge clk_ph2 or negedge rst) begin
      if (!rst) begin
         cycle_q <= CYC_RESET;
         ir_q    <= IR_RESET;
         dl_q    <= 8'h00;
         pcl_q   <= RESET_PC[7:0];
         pch_q   <= RESET_PC[15:8];
         abl_q   <= RESET_PC[7:0];
         abh_q   <= RESET_PC[15:8];
      end else begin
         cycle_q <= cycle_d;
         ir_q    <= ir_d;
         dl_q    <= bus.data_in;
         pcl_q   <= pc_d[7:0];
         pch_q   <= pc_d[15:8];
         abl_q   <= abl_d;
         abh_q   <= abh_d;
      end
   end

   assign bus.cycle = cycle_q;
   assign bus.IR    = ir_q;
   assign bus.DL    = dl_q;
   assign bus.pc    = {pch_q, pcl_q};
   assign bus.addr  = {abh_q, abl_q};
   assign bus.sync  = (cycle_q == CYC_FETCH);

endmodule

// File: tb/tb_cycle_pc_unit.sv
// Directed bench for cycle_pc_unit: reset, opcode/operand fetch, absolute
// addressing, PC wrap/carry, cycle counter corners and bus wired-AND.
module tb_cycle_pc_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   cycle_pc_unit_if bus();

   cycle_pc_unit #(.RESET_PC(16'h8000)) dut (
      .clk_ph2 (clk),
      .rst     (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic clr_ctl();
      bus.I_cycle = 0; bus.R_cycle = 0;
      bus.PCL_ADL = 0; bus.PCH_ADH = 0; bus.ADD_ADL = 0; bus.DL_ADH = 0;
      bus.ADL_ABL = 0; bus.ADH_ABH = 0;
      bus.I_PC = 0; bus.PCL_PCL = 0; bus.PCH_PCH = 0; bus.ADL_PCL = 0; bus.ADH_PCH = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Opcode/operand fetch controls: PC onto address bus, PC increments.
   task automatic fetch_ctl(input logic [7:0] d, input logic last);
      clr_ctl();
      bus.PCL_ADL = 1; bus.PCH_ADH = 1; bus.ADL_ABL = 1; bus.ADH_ABH = 1;
      bus.I_PC = 1; bus.PCL_PCL = 1; bus.PCH_PCH = 1;
      bus.I_cycle = ~last; bus.R_cycle = last;
      bus.data_in = d;
   endtask

   task automatic test_reset();
      clr_ctl();
      bus.data_in = 8'h00; bus.add_in = 8'h00;
      #12;
      n_vec++; if (bus.cycle !== 3'd7)     begin n_err++; $display("FAIL rst_cycle got %h want 7", bus.cycle); end
      n_vec++; if (bus.IR !== 8'hEA)       begin n_err++; $display("FAIL rst_ir got %h want ea", bus.IR); end
      n_vec++; if (bus.DL !== 8'h00)       begin n_err++; $display("FAIL rst_dl got %h want 00", bus.DL); end
      n_vec++; if (bus.pc !== 16'h8000)    begin n_err++; $display("FAIL rst_pc got %h want 8000", bus.pc); end
      n_vec++; if (bus.addr !== 16'h8000)  begin n_err++; $display("FAIL rst_addr got %h want 8000", bus.addr); end
      n_vec++; if (bus.sync !== 1'b0)      begin n_err++; $display("FAIL rst_sync got %b want 0", bus.sync); end
   endtask

   task automatic test_reset_release();
      @(negedge clk);
      rst_n = 1'b1;
      fetch_ctl(8'h00, 1'b1);
      tick();
      n_vec++; if (bus.cycle !== 3'd0)     begin n_err++; $display("FAIL rel_cycle got %h want 0", bus.cycle); end
      n_vec++; if (bus.addr !== 16'h8000)  begin n_err++; $display("FAIL rel_addr got %h want 8000", bus.addr); end
      n_vec++; if (bus.pc !== 16'h8001)    begin n_err++; $display("FAIL rel_pc got %h want 8001", bus.pc); end
      n_vec++; if (bus.sync !== 1'b1)      begin n_err++; $display("FAIL rel_sync got %b want 1", bus.sync); end
      n_vec++; if (bus.IR !== 8'hEA)       begin n_err++; $display("FAIL rel_ir got %h want ea", bus.IR); end
   endtask

   task automatic test_adc_imm();
      fetch_ctl(8'h69, 1'b0);
      tick();
      n_vec++; if (bus.IR !== 8'h69)       begin n_err++; $display("FAIL imm_ir got %h want 69", bus.IR); end
      n_vec++; if (bus.cycle !== 3'd1)     begin n_err++; $display("FAIL imm_cyc1 got %h want 1", bus.cycle); end
      n_vec++; if (bus.pc !== 16'h8002)    begin n_err++; $display("FAIL imm_pc1 got %h want 8002", bus.pc); end
      n_vec++; if (bus.sync !== 1'b0)      begin n_err++; $display("FAIL imm_sync1 got %b want 0", bus.sync); end
      fetch_ctl(8'h05, 1'b1);
      tick();
      n_vec++; if (bus.cycle !== 3'd0)     begin n_err++; $display("FAIL imm_cyc0 got %h want 0", bus.cycle); end
      n_vec++; if (bus.pc !== 16'h8003)    begin n_err++; $display("FAIL imm_pc2 got %h want 8003", bus.pc); end
      n_vec++; if (bus.DL !== 8'h05)       begin n_err++; $display("FAIL imm_dl got %h want 05", bus.DL); end
      n_vec++; if (bus.IR !== 8'h69)       begin n_err++; $display("FAIL imm_ir_hold got %h want 69", bus.IR); end
      n_vec++; if (bus.addr !== 16'h8002)  begin n_err++; $display("FAIL imm_addr got %h want 8002", bus.addr); end
   endtask

   task automatic test_adc_abs();
      fetch_ctl(8'h6D, 1'b0);
      tick();
      fetch_ctl(8'h12, 1'b0);
      tick();
      n_vec++; if (bus.cycle !== 3'd2)     begin n_err++; $display("FAIL abs_cyc2 got %h want 2", bus.cycle); end
      n_vec++; if (bus.DL !== 8'h12)       begin n_err++; $display("FAIL abs_dl got %h want 12", bus.DL); end
      n_vec++; if (bus.pc !== 16'h8005)    begin n_err++; $display("FAIL abs_pc1 got %h want 8005", bus.pc); end
      clr_ctl();
      bus.ADD_ADL = 1; bus.DL_ADH = 1; bus.ADL_ABL = 1; bus.ADH_ABH = 1; bus.I_cycle = 1;
      bus.add_in = 8'h34; bus.data_in = 8'h12;
      tick();
      n_vec++; if (bus.addr !== 16'h1234)  begin n_err++; $display("FAIL abs_addr got %h want 1234", bus.addr); end
      n_vec++; if (bus.pc !== 16'h8005)    begin n_err++; $display("FAIL abs_pc_hold got %h want 8005", bus.pc); end
      n_vec++; if (bus.cycle !== 3'd3)     begin n_err++; $display("FAIL abs_cyc3 got %h want 3", bus.cycle); end
      n_vec++; if (bus.IR !== 8'h6D)       begin n_err++; $display("FAIL abs_ir got %h want 6d", bus.IR); end
   endtask

   task automatic test_reset_mid();
      fetch_ctl(8'h55, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.cycle !== 3'd7)     begin n_err++; $display("FAIL mid_cycle got %h want 7", bus.cycle); end
      n_vec++; if (bus.IR !== 8'hEA)       begin n_err++; $display("FAIL mid_ir got %h want ea", bus.IR); end
      n_vec++; if (bus.pc !== 16'h8000)    begin n_err++; $display("FAIL mid_pc got %h want 8000", bus.pc); end
      n_vec++; if (bus.addr !== 16'h8000)  begin n_err++; $display("FAIL mid_addr got %h want 8000", bus.addr); end
      tick();
      n_vec++; if (bus.pc !== 16'h8000)    begin n_err++; $display("FAIL mid_pc_held got %h want 8000", bus.pc); end
      test_reset_release();
   endtask

   task automatic test_pc_wrap();
      clr_ctl();
      bus.ADL_PCL = 1; bus.ADH_PCH = 1; bus.data_in = 8'h12;
      tick();
      n_vec++; if (bus.pc !== 16'hFFFF)    begin n_err++; $display("FAIL wrap_load got %h want ffff", bus.pc); end
      n_vec++; if (bus.cycle !== 3'd0)     begin n_err++; $display("FAIL wrap_cyc_hold got %h want 0", bus.cycle); end
      clr_ctl();
      bus.I_PC = 1; bus.PCL_PCL = 1; bus.PCH_PCH = 1;
      tick();
      n_vec++; if (bus.pc !== 16'h0000)    begin n_err++; $display("FAIL wrap_pc got %h want 0000", bus.pc); end
      clr_ctl();
      bus.ADD_ADL = 1; bus.add_in = 8'hFF; bus.DL_ADH = 1; bus.ADL_PCL = 1; bus.ADH_PCH = 1;
      bus.PCL_PCL = 1; bus.PCH_PCH = 1;
      tick();
      n_vec++; if (bus.pc !== 16'h12FF)    begin n_err++; $display("FAIL carry_load got %h want 12ff", bus.pc); end
      clr_ctl();
      tick();
      n_vec++; if (bus.pc !== 16'h12FF)    begin n_err++; $display("FAIL pc_hold got %h want 12ff", bus.pc); end
      bus.I_PC = 1; bus.PCL_PCL = 1; bus.PCH_PCH = 1;
      tick();
      n_vec++; if (bus.pc !== 16'h1300)    begin n_err++; $display("FAIL carry_pc got %h want 1300", bus.pc); end
   endtask

   task automatic test_cycle_counter();
      clr_ctl();
      bus.I_cycle = 1;
      tick(); tick();
      n_vec++; if (bus.cycle !== 3'd2)     begin n_err++; $display("FAIL cyc_inc got %h want 2", bus.cycle); end
      bus.R_cycle = 1;
      tick();
      n_vec++; if (bus.cycle !== 3'd0)     begin n_err++; $display("FAIL cyc_both got %h want 0", bus.cycle); end
      bus.R_cycle = 0;
      for (int i = 0; i < 7; i++) tick();
      n_vec++; if (bus.cycle !== 3'd7)     begin n_err++; $display("FAIL cyc_seven got %h want 7", bus.cycle); end
      tick();
      n_vec++; if (bus.cycle !== 3'd0)     begin n_err++; $display("FAIL cyc_wrap got %h want 0", bus.cycle); end
      n_vec++; if (bus.sync !== 1'b1)      begin n_err++; $display("FAIL cyc_sync got %b want 1", bus.sync); end
   endtask

   task automatic test_dual_drive();
      clr_ctl();
      bus.ADD_ADL = 1; bus.add_in = 8'hF0; bus.ADL_PCL = 1; bus.ADH_PCH = 1;
      tick();
      n_vec++; if (bus.pc !== 16'hFFF0)    begin n_err++; $display("FAIL dual_pcload got %h want fff0", bus.pc); end
      clr_ctl();
      bus.PCL_ADL = 1; bus.ADD_ADL = 1; bus.add_in = 8'h3C; bus.ADL_ABL = 1;
      tick();
      n_vec++; if (bus.addr !== 16'h8030)  begin n_err++; $display("FAIL dual_abl got %h want 8030", bus.addr); end
      clr_ctl();
      bus.ADL_ABL = 1; bus.ADH_ABH = 1;
      tick();
      n_vec++; if (bus.addr !== 16'hFFFF)  begin n_err++; $display("FAIL precharge got %h want ffff", bus.addr); end
   endtask

   initial begin
      test_reset();
      test_reset_release();
      test_adc_imm();
      test_adc_abs();
      test_reset_mid();
      test_pc_wrap();
      test_cycle_counter();
      test_dual_drive();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cycle_pc_unit.md
CYCLE_PC_UNIT -- requirements
Module: cycle_pc_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC/address value loaded at reset (vector fetch out of scope).
REQ-002 SHALL have port: clk_ph2  in  1  clock phase 2; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: I_cycle, R_cycle  in  1 each  cycle counter increment / reset requests from the instruction decoder.
REQ-005 SHALL have ports: PCL_ADL, PCH_ADH, ADD_ADL, DL_ADH  in  1 each  ADL/ADH internal bus drive enables.
REQ-006 SHALL have ports: ADL_ABL, ADH_ABH  in  1 each  address register load enables.
REQ-007 SHALL have ports: I_PC, PCL_PCL, PCH_PCH, ADL_PCL, ADH_PCH  in  1 each  PC increment and PC source selects.
REQ-008 SHALL have ports: data_in  in  8  memory read data; add_in  in  8  ALU ADD register.
REQ-009 SHALL have ports: cycle  out  3  current instruction cycle; IR  out  8  instruction register; DL  out  8  data latch.
REQ-010 SHALL have ports: pc  out  16  program counter; addr  out  16  {ABH,ABL}; sync  out  1  opcode-fetch indicator.

Function
REQ-011 All inputs SHALL be sampled on the rising edge of clk_ph2. Control inputs registered by the decoder on edge N therefore take effect on edge N+1.
REQ-012 Cycle counter: R_cycle=1 -> 0; else I_cycle=1 -> cycle+1, wrapping 7->0; else hold. R_cycle SHALL win when both are asserted.
REQ-013 IR SHALL load data_in on an edge where cycle==0 (pre-edge value); otherwise it SHALL hold. The decoder thus sees the old IR during cycle 0 and the new IR from cycle 1.
REQ-014 DL SHALL load data_in on every edge.
REQ-015 ADL bus (combinational, internal): precharged 8'hFF. Each enabled source (PCL via PCL_ADL, add_in via ADD_ADL) SHALL be bitwise ANDed in; with no source enabled the bus SHALL read 8'hFF.
REQ-016 ADH bus: same wired-AND rule with sources PCH (PCH_ADH) and DL (DL_ADH).
REQ-017 ABL SHALL load the ADL bus when ADL_ABL=1 and otherwise hold; ABH SHALL follow the same rule with the ADH bus and ADH_ABH.
REQ-018 PC low source: ADL_PCL ? ADL bus : PCL. PC high source: ADH_PCH ? ADH bus : PCH. ADL_PCL/ADH_PCH SHALL win over PCL_PCL/PCH_PCH when both are asserted.
REQ-019 Next PC SHALL be {high source, low source} + I_PC, a 16-bit add with PCL carry into PCH, wrapping 16'hFFFF -> 16'h0000.
REQ-020 With I_PC=0 and no ADL_PCL/ADH_PCH asserted, PC SHALL hold.
REQ-021 sync SHALL equal (cycle==0), derived only from the registered cycle, with no combinational path from inputs.
REQ-022 addr SHALL be {ABH,ABL} with no combinational path from inputs.

Reset
REQ-023 rst=0 SHALL asynchronously force: cycle=3'd7; IR=8'hEA; DL=8'h00; pc=RESET_PC; ABL/ABH=RESET_PC bytes; sync=0.
REQ-024 Cycle=7 after reset SHALL cause the decoder's default branch to issue R_cycle.
REQ-025 Reset asserted mid-instruction SHALL abandon it immediately with no partial PC/IR update. Normal operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-026 Reset release, RESET_PC=16'h8000: decoder-like stim R_cycle+PCL_ADL+PCH_ADH+ADL_ABL+ADH_ABH+I_PC+PCL_PCL+PCH_PCH -> after 1 edge cycle=0, addr=8000, pc=8001, sync=1.
REQ-027 ADC #imm stream (data_in 69 at cycle0, then 05): IR=69 after cycle-0 edge, cycle 0->1->0, pc advances 8001->8002->8003, DL=05.
REQ-028 ADC abs: cycle-2 stim ADD_ADL+DL_ADH+ADL_ABL+ADH_ABH with add_in=34, DL=12 -> addr=1234, pc unchanged, cycle=3.
REQ-029 PC wrap: pc=FFFF, I_PC+PCL_PCL+PCH_PCH -> pc=0000. Carry check: pc=12FF -> 1300.
REQ-030 Simultaneous I_cycle+R_cycle at cycle=2 -> cycle=0. Wrap: cycle=7 with I_cycle -> 0. Dual ADL drive PCL=F0, add_in=3C -> ABL=30.
REQ-031 rst pulsed low at cycle=3 of ADC abs -> cycle=7, IR=EA, pc=RESET_PC immediately, without waiting for a clock edge.
